// File: rtl/expr_seq_ctrl.sv
// expr_seq_ctrl: sequencing controller for an ASCII arithmetic-expression
// datapath. Accepts one character per handshake, validates the grammar
// "digit (op digit)* =", evaluates with '*' binding tighter than '+', and
// reports a W-bit result or an error through an output handshake.
// Optional build macro: EXPR_SEQ_OVF_EN adds out_ovf, a sticky overflow
// indication qualified by out_valid.
module expr_seq_ctrl #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_char,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_result,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
`ifdef EXPR_SEQ_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  typedef enum logic [1:0] {
    EXP_NUM = 2'd0,
    EXP_OP  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q;
  logic [W-1:0] sum_q;
  logic [W-1:0] term_q;
  logic [W-1:0] out_result_q;
  logic         out_err_q;
  logic         out_valid_q;
  logic         in_ready_q;

  logic         is_digit;
  logic         is_add;
  logic         is_mul;
  logic         is_eq;
  logic [3:0]   digit_val;
  logic [W-1:0] prod_w;
  logic [W-1:0] sum_w;
  logic         in_xfer;
  logic         out_xfer;

`ifdef EXPR_SEQ_OVF_EN
  logic           ovf_q;
  logic           out_ovf_q;
  logic [W+3:0]   prod_ext;
  logic [W:0]     sum_ext;
  logic           mul_ovf;
  logic           add_ovf;
`endif

  // Character classification and the truncated arithmetic for this cycle
  always_comb begin
    is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
    is_add    = (in_char == 8'h2B);
    is_mul    = (in_char == 8'h2A);
    is_eq     = (in_char == 8'h3D);
    digit_val = in_char[3:0];
    prod_w    = term_q * W'(digit_val);
    sum_w     = sum_q + term_q;
    in_xfer   = in_valid && in_ready_q;
    out_xfer  = out_valid_q && out_ready;
  end

`ifdef EXPR_SEQ_OVF_EN
  // Full-width products/sums expose bits lost to truncation
  always_comb begin
    prod_ext = {4'b0000, term_q} * {{W{1'b0}}, digit_val};
    sum_ext  = {1'b0, sum_q} + {1'b0, term_q};
    mul_ovf  = |prod_ext[W+3:W];
    add_ovf  = sum_ext[W];
  end
`endif

  // Expression FSM with accumulators and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EXP_NUM;
      sum_q        <= '0;
      term_q       <= ONE;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef EXPR_SEQ_OVF_EN
      ovf_q        <= 1'b0;
      out_ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        EXP_NUM: begin
          if (in_xfer) begin
            if (is_digit) begin
              term_q  <= prod_w;
              state_q <= EXP_OP;
`ifdef EXPR_SEQ_OVF_EN
              ovf_q   <= ovf_q | mul_ovf;
`endif
            end else begin
              out_result_q <= '0;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              in_ready_q   <= 1'b0;
              state_q      <= HOLD;
`ifdef EXPR_SEQ_OVF_EN
              out_ovf_q    <= 1'b0;
`endif
            end
          end
        end
        EXP_OP: begin
          if (in_xfer) begin
            if (is_mul) begin
              state_q <= EXP_NUM;
            end else if (is_add) begin
              sum_q   <= sum_w;
              term_q  <= ONE;
              state_q <= EXP_NUM;
`ifdef EXPR_SEQ_OVF_EN
              ovf_q   <= ovf_q | add_ovf;
`endif
            end else if (is_eq) begin
              out_result_q <= sum_w;
              out_err_q    <= 1'b0;
              out_valid_q  <= 1'b1;
              in_ready_q   <= 1'b0;
              state_q      <= HOLD;
`ifdef EXPR_SEQ_OVF_EN
              out_ovf_q    <= ovf_q | add_ovf;
`endif
            end else begin
              out_result_q <= '0;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              in_ready_q   <= 1'b0;
              state_q      <= HOLD;
`ifdef EXPR_SEQ_OVF_EN
              out_ovf_q    <= 1'b0;
`endif
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            sum_q       <= '0;
            term_q      <= ONE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= EXP_NUM;
`ifdef EXPR_SEQ_OVF_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= EXP_NUM;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
`ifdef EXPR_SEQ_OVF_EN
  assign out_ovf    = out_ovf_q;
`endif

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Directed testbench for expr_seq_ctrl (W=10) with hand-computed results.
module tb_expr_seq_ctrl;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_char;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_result;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;
`ifdef EXPR_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  expr_seq_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_char    (in_char),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef EXPR_SEQ_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one character and wait (bounded) until it is accepted.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input byte c, output int cycles);
    logic acc;
    in_char  = c;
    in_valid = 1'b1;
    cycles   = 0;
    acc      = 1'b0;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_str(input string s);
    int n;
    for (int i = 0; i < s.len(); i++) send(s[i], n);
  endtask

  // With out_ready=1: report visible one cycle after the last character,
  // in_ready low for exactly that cycle.
  task automatic expect_res(input string tag, input int res, input logic err);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(out_result), 32'(res));
    check({tag, "_err"}, 32'(out_err), 32'(err));
    check({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid_lo"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_char   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Precedence: 1*2*3+4 = 10
    send_str("1*2*3+4=");
    expect_res("e1", 10, 1'b0);

    // Back-to-back expressions, accumulators cleared between them
    send_str("2+3*4=");
    expect_res("e2", 14, 1'b0);
    send_str("7=");
    expect_res("e3", 7, 1'b0);

    // Truncation: 9^4 = 6561 mod 1024 = 417
    send_str("9*9*9*9=");
`ifdef EXPR_SEQ_OVF_EN
    check("e4_ovf", 32'(out_ovf), 32'd1);
`endif
    expect_res("e4", 417, 1'b0);
    send_str("1+1=");
`ifdef EXPR_SEQ_OVF_EN
    check("e5_ovf", 32'(out_ovf), 32'd0);
`endif
    expect_res("e5", 2, 1'b0);

    // Grammar errors: consecutive operators, multi-digit operand, illegal char
    send_str("1++");
`ifdef EXPR_SEQ_OVF_EN
    check("err1_ovf", 32'(out_ovf), 32'd0);
`endif
    expect_res("err1", 0, 1'b1);
    send_str("12");
    expect_res("err2", 0, 1'b1);
    send_str("a");
    expect_res("err3", 0, 1'b1);
    send_str("=");
    expect_res("err4", 0, 1'b1);

    // Backpressure: report held stable, next character not consumed
    out_ready = 1'b0;
    send_str("3*4=");
    in_char  = "5";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(out_result), 32'd12);
      check("bp_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send("5", n);
    check("bp_accept_cycles", 32'(n), 32'd2);
    send_str("=");
    expect_res("bp_next", 5, 1'b0);

    // Asynchronous reset mid-expression
    send_str("5*6");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst1_rdy", 32'(in_ready), 32'd1);
    check("arst1_valid", 32'(out_valid), 32'd0);
    check("arst1_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_str("8=");
    expect_res("arst1_after", 8, 1'b0);

    // Asynchronous reset while a report is held
    out_ready = 1'b0;
    send_str("3=");
    check("arst2_pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst2_valid", 32'(out_valid), 32'd0);
    check("arst2_result", 32'(out_result), 32'd0);
    check("arst2_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_str("6*7+1=");
    expect_res("arst2_after", 43, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_seq_ctrl.md
Name: expr_seq_ctrl

Overview:
Sequencing controller for the ASCII arithmetic-expression datapath. It accepts one ASCII character per handshake, validates the grammar "digit (op digit)* =", and evaluates with '*' binding tighter than '+'. It delivers a W-bit result, or an error flag, through an output handshake. It sits between a character source (UART/keyboard/bench) and downstream display or consumer logic.

Parameters:
W, 10, result and accumulator width; all arithmetic is modulo 2^W.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_char  input  8  ASCII character
in_valid  input  1  in_char is valid this cycle
in_ready  output  1  controller can accept a character
out_result  output  W  evaluated result, held while out_valid is high
out_err  output  1  the expression was malformed; qualified by out_valid
out_valid  output  1  result/error is available
out_ready  input  1  consumer accepts the result

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Reset: state=EXP_NUM, sum=0, term=1, out_result=0, out_err=0, out_valid=0, in_ready=1. Reset mid-expression discards all partial state immediately.
- Character classes:
  - DIGIT: '0'..'9' (0x30–0x39), value d = in_char − 0x30, single-digit operands only.
  - ADD: '+'. MUL: '*'. EQ: '='.
  - Anything else is ILLEGAL.
- States: EXP_NUM, EXP_OP, HOLD.
- EXP_NUM (in_ready=1):
  - DIGIT: term <= term*d (truncate to W), go to EXP_OP.
  - Any other character: error; go to HOLD with out_err=1, out_result=0.
- EXP_OP (in_ready=1):
  - MUL: go to EXP_NUM; term unchanged.
  - ADD: sum <= sum+term (truncate), term <= 1, go to EXP_NUM.
  - EQ: out_result <= sum+term (truncate), out_err <= 0, go to HOLD.
  - DIGIT or ILLEGAL: error; go to HOLD with out_err=1, out_result=0.
- HOLD (in_ready=0, out_valid=1):
  - out_result and out_err are stable until the output transfer.
  - On the output transfer: sum<=0, term<=1, out_valid<=0, go to EXP_NUM. in_ready rises on the following cycle; there is no same-cycle bypass.
- Latency: the '=' (or erroring character) is accepted in cycle N; out_valid is high in cycle N+1.
- in_ready is a pure function of state (registered); it never depends combinationally on in_valid.
- Characters presented while in_ready=0 are not consumed; the source must hold them.
- The multiply is W×4 bits, truncated to W. The add is W+W bits, truncated to W.
- Any character arriving after an error is not consumed until the error report has been transferred.

Optional Feature:
- Macro: EXPR_SEQ_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), qualified by out_valid.
  - A sticky internal flag is set when any multiply or add result exceeds 2^W−1 before truncation.
  - out_ovf reflects the flag in HOLD.
  - The flag is cleared on reset and on the output transfer.
  - On an error report, out_ovf=0.
- Undefined: the port and the flag logic are absent; truncation behaviour is identical.

Test Plan:
- Stream "1*2*3+4=" with out_ready=1 → one out_valid pulse, out_result=10, out_err=0; in_ready low exactly one cycle.
- Stream "2+3*4=" then "7=" back-to-back → results 14 then 7; accumulators are reset between expressions.
- Stream "9*9*9*9=" (W=10) → out_result=417 (6561 mod 1024); with EXPR_SEQ_OVF_EN, out_ovf=1. A following "1+1=" → 2 with out_ovf=0.
- Stream "1++"; and separately "12=" and "a=" → out_err=1, out_result=0 after the offending character. The offending character is consumed; the next '+', '=' or character waits in HOLD.
- Send "3*4=" and hold out_ready=0 for 5 cycles → out_valid, out_result=12 and in_ready=0 stay stable. The next character (in_valid=1) is not consumed until one cycle after out_ready=1.
- Send "5*6" then assert rst_n=0 asynchronously mid-cycle → all outputs return to reset values immediately. After release, "8=" → 8.
